// File: rtl/cpu_controller_pkg.sv
// Shared types and encodings for the cpu_controller control FSM and its instruction decoder.
package cpu_ctrl_pkg;

    localparam int DW = 16;
    localparam int RW = 3;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WIMM,
        S_GETA,
        S_GETB,
        S_ALU,
        S_WREG,
        S_HALT
    } state_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_MDATA  = 2'b00;
    localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
    localparam logic [1:0] VSEL_PC     = 2'b10;
    localparam logic [1:0] VSEL_C      = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    // One-hot-ish instruction class; alu_rr covers ADD and AND (both read A and B and write back).
    typedef struct packed {
        logic mov_imm;
        logic mov_reg;
        logic alu_rr;
        logic cmp;
        logic mvn;
        logic legal;
    } iclass_t;

endpackage

// File: rtl/cpu_controller_if.sv
// Instruction-source / datapath-control bundle; the controller sits on the slave side.
interface cpu_ctrl_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    logic [DW-1:0] in;
    logic          load;
    logic          s;
    logic          w;
    logic          illegal;
    logic [RW-1:0] readnum;
    logic [RW-1:0] writenum;
    logic          write;
    logic [1:0]    vsel;
    logic          loada;
    logic          loadb;
    logic          asel;
    logic          bsel;
    logic [1:0]    shift;
    logic [1:0]    ALUop;
    logic          loadc;
    logic          loads;
    logic [DW-1:0] sximm8;
    logic [DW-1:0] sximm5;

    modport master (
        output in, load, s,
        input  w, illegal, readnum, writenum, write, vsel, loada, loadb,
               asel, bsel, shift, ALUop, loadc, loads, sximm8, sximm5
    );

    modport slave (
        input  in, load, s,
        output w, illegal, readnum, writenum, write, vsel, loada, loadb,
               asel, bsel, shift, ALUop, loadc, loads, sximm8, sximm5
    );
endinterface

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational IR field extraction, immediate sign extension and instruction classification.
module instr_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic [DW-1:0] ir_i,
    output logic [1:0]    op_o,
    output logic [RW-1:0] rn_o,
    output logic [RW-1:0] rd_o,
    output logic [RW-1:0] rm_o,
    output logic [1:0]    sh_o,
    output logic [DW-1:0] sximm8_o,
    output logic [DW-1:0] sximm5_o,
    output iclass_t       cls_o
);
    logic [2:0] opcode;

    assign opcode   = ir_i[15:13];
    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign sximm8_o = {{(DW-8){ir_i[7]}}, ir_i[7:0]};
    assign sximm5_o = {{(DW-5){ir_i[4]}}, ir_i[4:0]};

    always_comb begin
        cls_o = '0;
        if (opcode == OPC_MOV) begin
            cls_o.mov_imm = (op_o == OP_MOV_IMM);
            cls_o.mov_reg = (op_o == OP_MOV_REG);
        end else if (opcode == OPC_ALU) begin
            cls_o.alu_rr = (op_o == OP_ADD) || (op_o == OP_AND);
            cls_o.cmp    = (op_o == OP_CMP);
            cls_o.mvn    = (op_o == OP_MVN);
        end
        cls_o.legal = cls_o.mov_imm | cls_o.mov_reg | cls_o.alu_rr | cls_o.cmp | cls_o.mvn;
    end
endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM sequencing register-file/ALU datapath strobes from a latched 16-bit IR.
// Optional CPU_ILLEGAL_TRAP_EN: undefined opcodes halt in S_HALT (illegal=1) instead of acting as NOPs.
module cpu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic      clk,
    input  logic      reset_n,
    cpu_ctrl_if.slave bus
);
    state_e        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;

    logic [1:0]    op;
    logic [RW-1:0] rn, rd, rm;
    logic [1:0]    sh;
    logic [DW-1:0] sximm8, sximm5;
    iclass_t       cls;

    logic          w, illegal, write, loada, loadb, asel, bsel, loadc, loads;
    logic [RW-1:0] readnum, writenum;
    logic [1:0]    vsel, shift, aluop;

    instr_decoder #(.DW(DW), .RW(RW)) u_dec (
        .ir_i     (ir_q),
        .op_o     (op),
        .rn_o     (rn),
        .rd_o     (rd),
        .rm_o     (rm),
        .sh_o     (sh),
        .sximm8_o (sximm8),
        .sximm5_o (sximm5),
        .cls_o    (cls)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // IR only moves while idle, so a load pulse mid-instruction cannot corrupt the decode.
    assign ir_d = (state_q == S_WAIT && bus.load) ? bus.in : ir_q;

    always_comb begin
        state_d  = state_q;
        w        = 1'b0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        readnum  = '0;
        writenum = '0;
        vsel     = VSEL_MDATA;
        shift    = 2'b00;
        aluop    = ALU_ADD;

        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (bus.s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cls.mov_imm)                 state_d = S_WIMM;
                else if (cls.mov_reg || cls.mvn) state_d = S_GETB;
                else if (cls.alu_rr || cls.cmp)  state_d = S_GETA;
                else begin
`ifdef CPU_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_WIMM: begin
                write    = 1'b1;
                vsel     = VSEL_SXIMM8;
                writenum = rn;
                state_d  = S_WAIT;
            end
            S_GETA: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = S_GETB;
            end
            S_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_ALU;
            end
            S_ALU: begin
                // op bits coincide with the ALU encoding for ADD/CMP/AND/MVN; MOV reg is 0 + B.
                asel    = cls.mov_reg;
                shift   = sh;
                aluop   = cls.mov_reg ? ALU_ADD : op;
                loadc   = !cls.cmp;
                loads   = cls.cmp;
                state_d = cls.cmp ? S_WAIT : S_WREG;
            end
            S_WREG: begin
                write    = 1'b1;
                vsel     = VSEL_C;
                writenum = rd;
                state_d  = S_WAIT;
            end
            S_HALT: begin
`ifdef CPU_ILLEGAL_TRAP_EN
                state_d = S_HALT;
`else
                state_d = S_WAIT;
`endif
            end
            default: state_d = S_WAIT;
        endcase
    end

`ifdef CPU_ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_HALT);
`else
    assign illegal = 1'b0;
`endif

    assign bus.w        = w;
    assign bus.illegal  = illegal;
    assign bus.readnum  = readnum;
    assign bus.writenum = writenum;
    assign bus.write    = write;
    assign bus.vsel     = vsel;
    assign bus.loada    = loada;
    assign bus.loadb    = loadb;
    assign bus.asel     = asel;
    assign bus.bsel     = bsel;
    assign bus.shift    = shift;
    assign bus.ALUop    = aluop;
    assign bus.loadc    = loadc;
    assign bus.loads    = loads;
    assign bus.sximm8   = sximm8;
    assign bus.sximm5   = sximm5;
endmodule
